// File: rtl/dma_burst_controller.sv
// dma_burst_controller: bus-master sequencer that copies cmd_len words from the
// device buffer into data memory. It takes the bus in bursts of up to BURST words
// through a BR/BG handshake and pulses dma_end once the transfer is complete.
module dma_burst_controller #(
  parameter int WORD  = 16,
  parameter int LEN_W = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  input  logic [WORD-1:0]  cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             BR,
  input  logic             BG,
  output logic [LEN_W-1:0] dev_idx,
  input  logic [WORD-1:0]  dev_data,
  output logic [WORD-1:0]  mem_addr,
  output logic [WORD-1:0]  mem_data,
  output logic             mem_write,
  input  logic             mem_ack,
  output logic             dma_end
);

  typedef enum logic [2:0] {IDLE, REQ, XFER, REL, DONE} state_t;

  // burst_cnt must be able to hold 0..BURST-1 (it never stores BURST itself)
  localparam int BC_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST - 1);

  state_t            state, state_nx;
  logic [WORD-1:0]   base;
  logic [LEN_W-1:0]  remaining;
  logic [BC_W-1:0]   burst_cnt;
  logic              word_done;
  logic              last_word;
  logic              burst_full;

  // A word retires only when the write strobe is actually up; acks otherwise are noise.
  assign word_done  = mem_write & mem_ack;
  assign last_word  = (remaining == LEN_W'(1));
  assign burst_full = (burst_cnt == BURST_LAST);

  // Address and data are straight combinational views of the current word index.
  assign mem_addr = base + WORD'(dev_idx);
  assign mem_data = dev_data;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Command latch and word/burst counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base      <= '0;
      remaining <= '0;
      dev_idx   <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          base      <= cmd_addr;
          remaining <= cmd_len;
          dev_idx   <= '0;
        end
        // every fresh tenure (including after a revoked grant) starts a new burst
        REQ: if (BG) burst_cnt <= '0;
        XFER: if (word_done) begin
          dev_idx   <= dev_idx + LEN_W'(1);
          remaining <= remaining - LEN_W'(1);
          burst_cnt <= burst_cnt + BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state and handshake outputs; the write strobe is gated by BG in-cycle.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    BR        = 1'b0;
    mem_write = 1'b0;
    dma_end   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = (cmd_len == '0) ? DONE : REQ;
      end
      REQ: begin
        BR = 1'b1;
        if (BG) state_nx = XFER;
      end
      XFER: begin
        BR        = 1'b1;
        mem_write = BG;
        if (!BG)                                   state_nx = REQ;  // grant revoked
        else if (mem_ack && (last_word || burst_full)) state_nx = REL;
      end
      REL: begin
        if (!BG) state_nx = (remaining != '0) ? REQ : DONE;
      end
      DONE: begin
        dma_end  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_burst_controller.sv
// Directed bench for dma_burst_controller: a CPU-side grant model (automatic
// one-cycle-lag or scripted), a device buffer returning 0xA000+index, and a
// monitor that logs every retired write for per-scenario checking.
module tb_dma_burst_controller;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_ready, BR, BG, mem_write, mem_ack, dma_end;
  logic [7:0]  dev_idx;
  logic [15:0] dev_data, mem_addr, mem_data;

  logic bg_auto, bg_man, bg_lag, ack_auto, ack_man;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  int   end_cnt  = 0;
  int   br_rises = 0;
  logic br_prev  = 1'b0;

  dma_burst_controller #(.WORD(16), .LEN_W(8), .BURST(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ready(cmd_ready), .BR(BR), .BG(BG), .dev_idx(dev_idx),
    .dev_data(dev_data), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write(mem_write), .mem_ack(mem_ack), .dma_end(dma_end)
  );

  always #5 clk = ~clk;

  assign BG       = bg_auto ? bg_lag : bg_man;
  assign mem_ack  = ack_auto ? 1'b1 : ack_man;
  assign dev_data = 16'hA000 + {8'h00, dev_idx};

  // CPU grants one cycle after it sees the request
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bg_lag <= 1'b0;
    else          bg_lag <= BR;
  end

  // monitor: inputs only change just after posedge, so mid-cycle values are final
  always @(negedge clk) begin
    if (mem_write && mem_ack) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
    end
    if (dma_end) end_cnt++;
    if (BR && !br_prev) br_rises++;
    br_prev = BR;
  end

  task automatic issue(input logic [15:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (dma_end) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    bg_auto = 1'b0; bg_man = 1'b0; ack_auto = 1'b0; ack_man = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (BR !== 1'b0)        begin errors++; $display("FAIL reset_BR got=%b exp=0", BR); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    checks++; if (dma_end !== 1'b0)   begin errors++; $display("FAIL reset_dma_end got=%b exp=0", dma_end); end
    checks++; if (dev_idx !== 8'h00)  begin errors++; $display("FAIL reset_dev_idx got=%h exp=00", dev_idx); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
  endtask

  task automatic test_nominal;
    int s0, e0, r0; logic ok; logic [15:0] ea;
    s0 = log_addr.size(); e0 = end_cnt; r0 = br_rises;
    bg_auto = 1'b1; ack_auto = 1'b1;
    issue(16'h0100, 8'd12);
    @(negedge clk);
    checks++; if (BR !== 1'b1) begin errors++; $display("FAIL nom_cmd_to_BR got=%b exp=1", BR); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL nom_no_early_write got=%b exp=0", mem_write); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nom_done_timeout got=0 exp=1"); end
    @(negedge clk); #1;
    checks++; if (dma_end !== 1'b0)   begin errors++; $display("FAIL nom_end_one_cycle got=%b exp=0", dma_end); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL nom_ready_after got=%b exp=1", cmd_ready); end
    checks++; if (log_addr.size() - s0 != 12) begin errors++; $display("FAIL nom_word_count got=%0d exp=12", log_addr.size() - s0); end
    for (int i = 0; i < 12; i++) begin
      ea = 16'h0100 + 16'(i);
      checks++; if (log_addr[s0+i] !== ea) begin errors++; $display("FAIL nom_addr[%0d] got=%h exp=%h", i, log_addr[s0+i], ea); end
      checks++; if (log_data[s0+i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL nom_data[%0d] got=%h exp=%h", i, log_data[s0+i], 16'hA000 + 16'(i)); end
    end
    checks++; if (br_rises - r0 != 3) begin errors++; $display("FAIL nom_bursts got=%0d exp=3", br_rises - r0); end
    checks++; if (end_cnt - e0 != 1)  begin errors++; $display("FAIL nom_end_pulses got=%0d exp=1", end_cnt - e0); end
  endtask

  task automatic test_partial;
    int s0, e0, r0; logic ok;
    s0 = log_addr.size(); e0 = end_cnt; r0 = br_rises;
    issue(16'h0200, 8'd6);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL part_done_timeout got=0 exp=1"); end
    @(negedge clk); #1;
    checks++; if (log_addr.size() - s0 != 6) begin errors++; $display("FAIL part_word_count got=%0d exp=6", log_addr.size() - s0); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (log_addr[s0+i] !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL part_addr[%0d] got=%h exp=%h", i, log_addr[s0+i], 16'h0200 + 16'(i)); end
    end
    checks++; if (br_rises - r0 != 2) begin errors++; $display("FAIL part_bursts got=%0d exp=2", br_rises - r0); end
    checks++; if (end_cnt - e0 != 1)  begin errors++; $display("FAIL part_end_pulses got=%0d exp=1", end_cnt - e0); end
  endtask

  task automatic test_zero_len;
    int s0, e0, r0;
    s0 = log_addr.size(); e0 = end_cnt; r0 = br_rises;
    issue(16'h0300, 8'd0);
    @(negedge clk);
    checks++; if (dma_end !== 1'b1)   begin errors++; $display("FAIL zero_end got=%b exp=1", dma_end); end
    checks++; if (BR !== 1'b0)        begin errors++; $display("FAIL zero_BR got=%b exp=0", BR); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL zero_ready_busy got=%b exp=0", cmd_ready); end
    @(negedge clk); #1;
    checks++; if (dma_end !== 1'b0)   begin errors++; $display("FAIL zero_end_drop got=%b exp=0", dma_end); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", cmd_ready); end
    checks++; if (br_rises - r0 != 0) begin errors++; $display("FAIL zero_no_BR got=%0d exp=0", br_rises - r0); end
    checks++; if (log_addr.size() - s0 != 0) begin errors++; $display("FAIL zero_no_write got=%0d exp=0", log_addr.size() - s0); end
    checks++; if (end_cnt - e0 != 1)  begin errors++; $display("FAIL zero_end_pulses got=%0d exp=1", end_cnt - e0); end
  endtask

  task automatic test_stall_revoke;
    int s0, e0; logic ok;
    s0 = log_addr.size(); e0 = end_cnt;
    bg_auto = 1'b0; ack_auto = 1'b0; bg_man = 1'b0; ack_man = 1'b0;
    issue(16'h0400, 8'd8);
    bg_man = 1'b1; ack_man = 1'b1;
    @(negedge clk);
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL stall_req_no_write got=%b exp=0", mem_write); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL stall_grant_to_write got=%b exp=1", mem_write); end
    checks++; if (mem_addr !== 16'h0400) begin errors++; $display("FAIL stall_addr0 got=%h exp=0400", mem_addr); end
    @(posedge clk); #1;
    ack_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (mem_addr !== 16'h0401) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=0401", i, mem_addr); end
      @(posedge clk); #1;
    end
    ack_man = 1'b1;
    @(posedge clk); #1;
    bg_man = 1'b0;
    @(negedge clk);
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL revoke_write got=%b exp=0", mem_write); end
    checks++; if (BR !== 1'b1)        begin errors++; $display("FAIL revoke_BR got=%b exp=1", BR); end
    checks++; if (mem_addr !== 16'h0402) begin errors++; $display("FAIL revoke_addr got=%h exp=0402", mem_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (BR !== 1'b1)     begin errors++; $display("FAIL revoke_req_BR got=%b exp=1", BR); end
    checks++; if (dev_idx !== 8'd2) begin errors++; $display("FAIL revoke_idx got=%0d exp=2", dev_idx); end
    bg_man = 1'b1;
    @(posedge clk); #1;
    bg_auto = 1'b1; ack_auto = 1'b1;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL regrant_write got=%b exp=1", mem_write); end
    checks++; if (mem_addr !== 16'h0402) begin errors++; $display("FAIL regrant_addr got=%h exp=0402", mem_addr); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout got=0 exp=1"); end
    @(negedge clk); #1;
    checks++; if (log_addr.size() - s0 != 8) begin errors++; $display("FAIL stall_word_count got=%0d exp=8", log_addr.size() - s0); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (log_addr[s0+i] !== 16'h0400 + 16'(i)) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, log_addr[s0+i], 16'h0400 + 16'(i)); end
      checks++; if (log_data[s0+i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, log_data[s0+i], 16'hA000 + 16'(i)); end
    end
    checks++; if (end_cnt - e0 != 1) begin errors++; $display("FAIL stall_end_pulses got=%0d exp=1", end_cnt - e0); end
  endtask

  task automatic test_busy_wrap;
    int s0, e0, r0; logic ok; logic seen; logic [15:0] ea;
    s0 = log_addr.size(); e0 = end_cnt; r0 = br_rises;
    issue(16'hFFFE, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_write) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL wrap_xfer_timeout got=0 exp=1"); end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 16'h1234; cmd_len = 8'd9;
    repeat (2) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout got=0 exp=1"); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (BR !== 1'b0)        begin errors++; $display("FAIL busy_no_queue_BR got=%b exp=0", BR); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL busy_ready got=%b exp=1", cmd_ready); end
    checks++; if (log_addr.size() - s0 != 4) begin errors++; $display("FAIL wrap_word_count got=%0d exp=4", log_addr.size() - s0); end
    for (int i = 0; i < 4; i++) begin
      ea = 16'hFFFE + 16'(i);
      checks++; if (log_addr[s0+i] !== ea) begin errors++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, log_addr[s0+i], ea); end
      checks++; if (log_data[s0+i] !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, log_data[s0+i], 16'hA000 + 16'(i)); end
    end
    checks++; if (br_rises - r0 != 1) begin errors++; $display("FAIL busy_bursts got=%0d exp=1", br_rises - r0); end
    checks++; if (end_cnt - e0 != 1)  begin errors++; $display("FAIL busy_end_pulses got=%0d exp=1", end_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    int s0, e0; logic ok; logic seen;
    e0 = end_cnt;
    issue(16'h0500, 8'd8);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (mem_write && dev_idx == 8'd2) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_word2_timeout got=0 exp=1"); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (BR !== 1'b0)        begin errors++; $display("FAIL rstmid_BR got=%b exp=0", BR); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_write got=%b exp=0", mem_write); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (end_cnt - e0 != 0)  begin errors++; $display("FAIL rstmid_no_end got=%0d exp=0", end_cnt - e0); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got=%b exp=1", cmd_ready); end
    s0 = log_addr.size();
    issue(16'h0600, 8'd3);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_new_timeout got=0 exp=1"); end
    @(negedge clk); #1;
    checks++; if (log_addr.size() - s0 != 3) begin errors++; $display("FAIL rstmid_new_count got=%0d exp=3", log_addr.size() - s0); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (log_addr[s0+i] !== 16'h0600 + 16'(i)) begin errors++; $display("FAIL rstmid_new_addr[%0d] got=%h exp=%h", i, log_addr[s0+i], 16'h0600 + 16'(i)); end
    end
    checks++; if (end_cnt - e0 != 1) begin errors++; $display("FAIL rstmid_new_end got=%0d exp=1", end_cnt - e0); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_partial;
    test_zero_len;
    test_stall_revoke;
    test_busy_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
